// File: rtl/sine_pkg.sv
// ============================================================================
// sine_pkg : shared types, default widths and threshold helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package sine_pkg;

  typedef logic [15:0] int16_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    SYNC = 3'd2,
    MEAS = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 24;

  // Upper threshold clamped to the all-ones value of a w-bit sample.
  function automatic logic [31:0] sat_hi(input logic [31:0] t, input logic [31:0] h, input int w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, t} + {1'b0, h};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

  function automatic logic [31:0] sat_lo(input logic [31:0] t, input logic [31:0] h);
    return (t > h) ? (t - h) : 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crossing_det.sv
// ============================================================================
// crossing_det : hysteresis comparator with re-arm flag
// Rev 1.0
// ============================================================================
`default_nettype none

module crossing_det #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic              o_rise,
  output logic              o_below_lo
);

  logic r_armed;

  assign o_below_lo = i_valid && (i_data <= i_lo);
  assign o_rise     = i_valid && r_armed && (i_data >= i_hi);

  // A rise consumes the arm even if the same sample is also below lo (zero band).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (i_clr) begin
      r_armed <= 1'b0;
    end else if (o_rise) begin
      r_armed <= 1'b0;
    end else if (o_below_lo) begin
      r_armed <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sine_analyzer.sv
// ============================================================================
// sine_analyzer : min/max/mid/amplitude/period monitor for a sine sample stream
// Optional: SINE_ANALYZER_CONT_EN selects continuous re-arming after each window.
// Rev 1.0
// ============================================================================
`default_nettype none

module sine_analyzer
  import sine_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HYST        = 16,
  parameter int NUM_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [DATA_W-1:0] thresh,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] meas_max,
  output logic [DATA_W-1:0] meas_min,
  output logic [DATA_W-1:0] meas_mid,
  output logic [DATA_W-1:0] meas_ampl,
  output logic [CNT_W-1:0]  meas_period
);

  localparam int                PC_W     = $clog2(NUM_PERIODS) + 1;
  localparam int                c_LOG2NP = $clog2(NUM_PERIODS);
  localparam logic [CNT_W-1:0]  c_TLAST  = {CNT_W{1'b1}} - CNT_W'(1);
  localparam logic [PC_W-1:0]   c_PLAST  = PC_W'(NUM_PERIODS - 1);
`ifdef SINE_ANALYZER_CONT_EN
  localparam state_t            c_AFTER_DONE = ARM;
  localparam bit                c_CONT       = 1'b1;
`else
  localparam state_t            c_AFTER_DONE = IDLE;
  localparam bit                c_CONT       = 1'b0;
`endif

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_hi, r_lo, r_max, r_min;
  logic [CNT_W-1:0]    r_tcnt, r_total;
  logic [PC_W-1:0]     r_pcnt;
  logic                r_err;
  logic                w_rise, w_below, w_active, w_to, w_fin, w_clr;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;

  assign w_active = s_valid && (r_state == ARM || r_state == SYNC || r_state == MEAS);
  assign w_to     = w_active && (r_tcnt == c_TLAST);
  assign w_fin    = (r_state == MEAS) && w_rise && (r_pcnt == c_PLAST);
  assign w_clr    = (r_state == IDLE) || (r_state == DONE);
  assign w_sum    = {1'b0, r_max} + {1'b0, r_min};
  assign w_diff   = r_max - r_min;
  assign err      = r_err;

  crossing_det #(.DATA_W(DATA_W)) u_cross (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (s_valid),
    .i_clr      (w_clr),
    .i_data     (s_data),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_rise     (w_rise),
    .o_below_lo (w_below)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // The arm flag is set by the ARM-state low sample, so the SYNC crossing is simply a rise.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = ARM;
      ARM:  if (w_to) w_next = DONE; else if (w_below) w_next = SYNC;
      SYNC: if (w_to) w_next = DONE; else if (w_rise) w_next = MEAS;
      MEAS: if (w_fin || w_to) w_next = DONE;
      DONE: w_next = c_AFTER_DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_tcnt      <= '0;
      r_err       <= 1'b0;
      r_max       <= '0;
      r_min       <= '0;
      r_total     <= '0;
      r_pcnt      <= '0;
      meas_max    <= '0;
      meas_min    <= '0;
      meas_mid    <= '0;
      meas_ampl   <= '0;
      meas_period <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_hi   <= DATA_W'(sat_hi(32'(thresh), 32'(HYST), DATA_W));
        r_lo   <= DATA_W'(sat_lo(32'(thresh), 32'(HYST)));
        r_tcnt <= '0;
        r_err  <= 1'b0;
      end else if (r_state == DONE && c_CONT) begin
        r_tcnt <= '0;
        r_err  <= 1'b0;
      end else if (w_active) begin
        r_tcnt <= r_tcnt + CNT_W'(1);
      end

      if (w_to && !w_fin) r_err <= 1'b1;

      // The closing crossing sample starts the next period, so it is excluded here.
      if (r_state == SYNC && w_rise) begin
        r_max   <= s_data;
        r_min   <= s_data;
        r_total <= CNT_W'(1);
        r_pcnt  <= '0;
      end else if (r_state == MEAS && s_valid) begin
        if (w_fin) begin
          meas_max    <= r_max;
          meas_min    <= r_min;
          meas_mid    <= DATA_W'(w_sum >> 1);
          meas_ampl   <= w_diff >> 1;
          meas_period <= r_total >> c_LOG2NP;
        end else begin
          if (s_data > r_max) r_max <= s_data;
          if (s_data < r_min) r_min <= s_data;
          r_total <= r_total + CNT_W'(1);
          if (w_rise) r_pcnt <= r_pcnt + PC_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sine_analyzer.sv
// ============================================================================
// tb_sine_analyzer : randomized sine windows checked against a sample-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sine_analyzer;

  localparam int NP = 4;
  localparam int HY = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [15:0] thresh = '0;
  logic        start = 1'b0;
  logic        start_to = 1'b0;
  logic        sel = 1'b0;

  logic        busy, done, err, busy_t, done_t, err_t;
  logic [15:0] mx, mn, md, am, mx_t, mn_t, md_t, am_t;
  logic [23:0] per;
  logic [7:0]  per_t;

  sine_analyzer #(.DATA_W(16), .CNT_W(24), .HYST(HY), .NUM_PERIODS(NP)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .thresh(thresh),
    .start(start), .busy(busy), .done(done), .err(err), .meas_max(mx), .meas_min(mn),
    .meas_mid(md), .meas_ampl(am), .meas_period(per)
  );

  sine_analyzer #(.DATA_W(16), .CNT_W(8), .HYST(HY), .NUM_PERIODS(NP)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .thresh(thresh),
    .start(start_to), .busy(busy_t), .done(done_t), .err(err_t), .meas_max(mx_t), .meas_min(mn_t),
    .meas_mid(md_t), .meas_ampl(am_t), .meas_period(per_t)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit vq[$];
  int dq[$];
  int e_max = 0, e_min = 0, e_mid = 0, e_amp = 0, e_per = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sine_at(input int n, input int off, input int amp, input int prd, input int ph);
    real x;
    x = real'(off) + real'(amp) * $sin(2.0 * 3.14159265358979 * real'(n + ph) / real'(prd));
    if (x < 0.0) x = 0.0;
    if (x > 65535.0) x = 65535.0;
    return $rtoi($floor(x + 0.5));
  endfunction

  // Walks the accepted samples: arm below lo, sync on hi, then NP rising crossings.
  function automatic void model(input bit v[$], input int d[$], input int hi, input int lo, input int tmax,
                                output int dcyc, output bit e, output int omx, output int omn, output int tot);
    int phase = 0, cnt = 0, ncross = 0;
    bit armed = 0;
    dcyc = -1; e = 0; omx = 0; omn = 0; tot = 0;
    for (int k = 0; k < v.size(); k++) begin
      if (!v[k]) continue;
      cnt++;
      if (phase == 0) begin
        if (d[k] <= lo) phase = 1;
      end else if (phase == 1) begin
        if (d[k] >= hi) begin phase = 2; omx = d[k]; omn = d[k]; tot = 1; armed = 0; end
      end else begin
        if (armed && d[k] >= hi) begin
          ncross++;
          armed = 0;
          if (ncross == NP) begin dcyc = k + 1; return; end
        end else if (d[k] <= lo) armed = 1;
        if (d[k] > omx) omx = d[k];
        if (d[k] < omn) omn = d[k];
        tot++;
      end
      if (cnt == tmax) begin dcyc = k + 1; e = 1; return; end
    end
  endfunction

  task automatic gen_sine(input int off, input int amp, input int prd, input int ph, input int vmode, input int len);
    int sidx = 0;
    bit v;
    vq.delete(); dq.delete();
    for (int k = 0; k < len; k++) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(k % 2) : bit'($urandom_range(0, 1));
      vq.push_back(v);
      dq.push_back(sine_at(sidx, off, amp, prd, ph));
      if (v) sidx++;
    end
  endtask

  task automatic run_queue(input string nm, input int th, input bit use_to, input int xk, input bit start_in_done);
    int hi, lo, dcyc, omx, omn, tot, ndone;
    bit e;
    hi = (th + HY > 65535) ? 65535 : th + HY;
    lo = (th - HY < 0) ? 0 : th - HY;
    model(vq, dq, hi, lo, use_to ? 255 : 16777215, dcyc, e, omx, omn, tot);
    if (use_to) begin e_max = 0; e_min = 0; e_mid = 0; e_amp = 0; e_per = 0; end
    if (!e) begin
      e_max = omx; e_min = omn; e_mid = (omx + omn) / 2; e_amp = (omx - omn) / 2; e_per = tot / NP;
    end
    sel = use_to;
    @(posedge clk); #1;
    if (use_to) start_to = 1'b1; else start = 1'b1;
    thresh = 16'(th); s_valid = 1'b1; s_data = 16'd0;
    @(negedge clk);
    check_eq({nm, "_busy_start"}, use_to ? busy_t : busy, 0);
    @(posedge clk); #1;
    start = 1'b0; start_to = 1'b0;
    thresh = 16'($urandom);
    ndone = 0;
    for (int k = 0; k < vq.size(); k++) begin
      s_valid = vq[k]; s_data = 16'(dq[k]);
      start = !use_to && ((k == xk) || (start_in_done && k == dcyc));
      @(negedge clk);
      if (k == dcyc) check_eq({nm, "_busy_done"}, use_to ? busy_t : busy, 1);
      if (use_to ? done_t : done) begin
        ndone++;
        if (ndone == 1) begin
          check_eq({nm, "_done_idx"}, k, dcyc);
          check_eq({nm, "_err"}, use_to ? err_t : err, e);
          check_eq({nm, "_max"}, use_to ? mx_t : mx, e_max);
          check_eq({nm, "_min"}, use_to ? mn_t : mn, e_min);
          check_eq({nm, "_mid"}, use_to ? md_t : md, e_mid);
          check_eq({nm, "_ampl"}, use_to ? am_t : am, e_amp);
          check_eq({nm, "_period"}, use_to ? 64'(per_t) : 64'(per), e_per);
        end
      end
      if (dcyc >= 0 && k == dcyc + 1) begin
        check_eq({nm, "_busy_after"}, use_to ? busy_t : busy, 0);
        check_eq({nm, "_err_hold"}, use_to ? err_t : err, e);
      end
      @(posedge clk); #1;
      if (dcyc >= 0 && k > dcyc + 2) break;
    end
    start = 1'b0; s_valid = 1'b0;
    check_eq({nm, "_done_count"}, ndone, 1);
  endtask

  initial begin
    int off, amp, prd, th, vm;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_max", mx, 0);
    check_eq("rst_period", per, 0);
    rst_n = 1'b1;

    gen_sine(2000, 1000, 100, 0, 0, 720);
    run_queue("base", 2000, 0, -1, 0);
    gen_sine(2000, 1000, 100, 0, 1, 1440);
    run_queue("half_valid", 2000, 0, -1, 0);
    gen_sine(2000, 1000, 100, 37, 0, 720);
    run_queue("restart_ignored", 2000, 0, 250, 1);

    gen_sine(2000, 1000, 100, 0, 0, 300);
    @(posedge clk); #1; start = 1'b1; thresh = 16'd2000;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 200; k++) begin s_valid = vq[k]; s_data = 16'(dq[k]); @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_max", mx, 0);
    @(posedge clk); #1; rst_n = 1'b1; s_valid = 1'b0;
    e_max = 0; e_min = 0; e_mid = 0; e_amp = 0; e_per = 0;
    gen_sine(2000, 1000, 100, 11, 0, 720);
    run_queue("after_abort", 2000, 0, -1, 0);

    gen_sine(1000, 1000, 100, 0, 0, 720);
    run_queue("lo_sat", 0, 0, -1, 0);
    gen_sine(64535, 1000, 80, 5, 2, 1800);
    run_queue("hi_sat", 65530, 0, -1, 0);

    vq.delete(); dq.delete();
    for (int k = 0; k < 600; k++) begin vq.push_back(bit'($urandom_range(0, 3) != 0)); dq.push_back(2000); end
    run_queue("timeout", 2000, 1, -1, 0);

    for (int i = 0; i < 5; i++) begin
      off = int'($urandom_range(3000, 60000));
      amp = int'($urandom_range(100, 3000));
      prd = int'($urandom_range(20, 150));
      th  = off + int'($urandom_range(0, amp / 2)) - amp / 4;
      vm  = int'($urandom_range(0, 2));
      gen_sine(off, amp, prd, int'($urandom_range(0, prd - 1)), vm, (7 * prd + 20) * (vm == 0 ? 1 : 3));
      run_queue($sformatf("rand%0d", i), th, 0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
